// File: rtl/mac_neuron_sequencer.sv
// Control stage for the MAC core: streams weight/activation pairs from two
// synchronous-read memories into the MAC, then captures and holds the result.
module mac_neuron_sequencer #(
  parameter int N        = 8,
  parameter int N_INPUTS = 16,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] weight_base,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] a_addr,
  input  logic [N-1:0]      w_rd_data,
  input  logic [N-1:0]      a_rd_data,
  output logic [N-1:0]      mac_weight,
  output logic [N-1:0]      mac_in,
  output logic              mac_forget,
  output logic              mac_oe,
  input  logic [N-1:0]      mac_out,
  output logic [N-1:0]      result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_INPUTS - 1);

  state_t state;
  logic   dv;
  logic   first_d1;
  logic   last_d1;
  logic   last_d2;
  logic   first_rd;
  logic   last_rd;

  // a_addr doubles as the pair index i, so the first/last flags come from it.
  assign first_rd  = mem_rd_en && (a_addr == '0);
  assign last_rd   = mem_rd_en && (a_addr == LAST);
  assign fsm_state = state;

  // The MAC accumulates every cycle, so data outside the read window is forced to 0.
  always_comb begin
    mac_weight = '0;
    mac_in     = '0;
    if (dv) begin
      mac_weight = w_rd_data;
      mac_in     = a_rd_data;
    end
  end

  // Result handshake: result is transferred on a cycle where result_valid and
  // result_ready are both high; result and result_valid stay stable until then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      mem_rd_en    <= 1'b0;
      w_addr       <= '0;
      a_addr       <= '0;
      dv           <= 1'b0;
      first_d1     <= 1'b0;
      last_d1      <= 1'b0;
      last_d2      <= 1'b0;
      mac_forget   <= 1'b0;
      mac_oe       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      dv         <= mem_rd_en;
      first_d1   <= first_rd;
      mac_forget <= first_d1;
      last_d1    <= last_rd;
      last_d2    <= last_d1;
      mac_oe     <= last_d2;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            busy      <= 1'b1;
            mem_rd_en <= 1'b1;
            w_addr    <= weight_base;
            a_addr    <= '0;
          end
        end
        FETCH: begin
          if (a_addr == LAST) begin
            mem_rd_en <= 1'b0;
            state     <= WAIT;
          end else begin
            w_addr <= w_addr + 1'b1;
            a_addr <= a_addr + 1'b1;
          end
        end
        WAIT: begin
          if (mac_oe) begin
            result       <= mac_out;
            result_valid <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
